// File: rtl/bm_expr_pkg.sv
// Shared opcode encodings and flag type for the bm_expr ALU pipeline.
package bm_expr_pkg;

    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_LAND = 5'd0;
    localparam logic [OPW-1:0] OP_LOR  = 5'd1;
    localparam logic [OPW-1:0] OP_EQ   = 5'd2;
    localparam logic [OPW-1:0] OP_NEQ  = 5'd3;
    localparam logic [OPW-1:0] OP_GT   = 5'd4;
    localparam logic [OPW-1:0] OP_GE   = 5'd5;
    localparam logic [OPW-1:0] OP_LT   = 5'd6;
    localparam logic [OPW-1:0] OP_LE   = 5'd7;
    localparam logic [OPW-1:0] OP_ADD  = 5'd8;
    localparam logic [OPW-1:0] OP_SUB  = 5'd9;
    localparam logic [OPW-1:0] OP_SHL  = 5'd10;
    localparam logic [OPW-1:0] OP_SHR  = 5'd11;
    localparam logic [OPW-1:0] OP_AND  = 5'd12;
    localparam logic [OPW-1:0] OP_OR   = 5'd13;
    localparam logic [OPW-1:0] OP_XOR  = 5'd14;
    localparam logic [OPW-1:0] OP_XNOR = 5'd15;
    localparam logic [OPW-1:0] OP_NOT  = 5'd16;
    localparam logic [OPW-1:0] OP_LNOT = 5'd17;
    localparam logic [OPW-1:0] OP_NEG  = 5'd18;
    localparam logic [OPW-1:0] OP_LAST = 5'd18;

    typedef struct packed {
        logic zero;
        logic carry;
        logic illegal;
    } bm_flags_t;

endpackage

// File: rtl/bm_expr_alu_core.sv
// Combinational opcode-selected ALU: (opcode, a, b) -> (result, flags).
// Define BM_EXPR_SAT_EN to make ADD/SUB saturate instead of wrapping.
module bm_expr_alu_core
    import bm_expr_pkg::*;
#(
    parameter int unsigned BITS = 32
) (
    input  logic [OPW-1:0]  opcode_i,
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic [BITS-1:0] result_o,
    output logic            zero_o,
    output logic            carry_o,
    output logic            illegal_o
);

    localparam logic [BITS-1:0] BitsVal = BITS'(BITS);

    logic          a_nz;
    logic          b_nz;
    logic          shift_oob;
    logic [BITS:0] sum;
    logic [BITS:0] diff;

    always_comb begin
        result_o  = '0;
        carry_o   = 1'b0;
        illegal_o = 1'b0;
        a_nz      = |a_i;
        b_nz      = |b_i;
        // The whole shift amount counts, so any b >= BITS flushes the operand.
        shift_oob = (b_i >= BitsVal);
        sum       = {1'b0, a_i} + {1'b0, b_i};
        diff      = {1'b0, a_i} - {1'b0, b_i};

        case (opcode_i)
            OP_LAND: result_o = BITS'(a_nz && b_nz);
            OP_LOR:  result_o = BITS'(a_nz || b_nz);
            OP_EQ:   result_o = BITS'(a_i == b_i);
            OP_NEQ:  result_o = BITS'(a_i != b_i);
            OP_GT:   result_o = BITS'(a_i > b_i);
            OP_GE:   result_o = BITS'(a_i >= b_i);
            OP_LT:   result_o = BITS'(a_i < b_i);
            OP_LE:   result_o = BITS'(a_i <= b_i);
            OP_ADD: begin
                carry_o  = sum[BITS];
`ifdef BM_EXPR_SAT_EN
                result_o = sum[BITS] ? '1 : sum[BITS-1:0];
`else
                result_o = sum[BITS-1:0];
`endif
            end
            OP_SUB: begin
                carry_o  = diff[BITS];
`ifdef BM_EXPR_SAT_EN
                result_o = diff[BITS] ? '0 : diff[BITS-1:0];
`else
                result_o = diff[BITS-1:0];
`endif
            end
            OP_SHL:  result_o = shift_oob ? '0 : (a_i << b_i);
            OP_SHR:  result_o = shift_oob ? '0 : (a_i >> b_i);
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_XNOR: result_o = a_i ~^ b_i;
            OP_NOT:  result_o = ~a_i;
            OP_LNOT: result_o = BITS'(!a_nz);
            OP_NEG:  result_o = -a_i;
            default: illegal_o = (opcode_i > OP_LAST);
        endcase

        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/bm_expr_alu_pipe.sv
// Pipelined valid/ready wrapper around bm_expr_alu_core with flags and a result counter.
// Optional build macro BM_EXPR_SAT_EN selects saturating ADD/SUB in the core.
module bm_expr_alu_pipe
    import bm_expr_pkg::*;
#(
    parameter int unsigned BITS     = 32,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPW-1:0]      opcode,
    input  logic [BITS-1:0]     a_in,
    input  logic [BITS-1:0]     b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     result,
    output logic                flag_zero,
    output logic                flag_carry,
    output logic                flag_illegal,
    output logic [CNT_BITS-1:0] op_count
);

    logic [STAGES-1:0]   vld_q;
    logic [STAGES-1:0]   adv;
    logic [BITS-1:0]     res_q [STAGES];
    bm_flags_t           flg_q [STAGES];
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    logic [BITS-1:0] core_res;
    bm_flags_t       core_flg;

    bm_expr_alu_core #(
        .BITS (BITS)
    ) u_core (
        .opcode_i  (opcode),
        .a_i       (a_in),
        .b_i       (b_in),
        .result_o  (core_res),
        .zero_o    (core_flg.zero),
        .carry_o   (core_flg.carry),
        .illegal_o (core_flg.illegal)
    );

    // Advance ripples back from the output so bubbles collapse and a full pipe streams.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready || !vld_q[STAGES-1];
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            adv[i] = !vld_q[i] || adv[i+1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (adv[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    res_q[0] <= core_res;
                    flg_q[0] <= core_flg;
                end
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (adv[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        res_q[i] <= res_q[i-1];
                        flg_q[i] <= flg_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready     = adv[0];
    assign out_valid    = vld_q[STAGES-1];
    assign result       = res_q[STAGES-1];
    assign flag_zero    = flg_q[STAGES-1].zero;
    assign flag_carry   = flg_q[STAGES-1].carry;
    assign flag_illegal = flg_q[STAGES-1].illegal;
    assign op_count     = cnt_q;

endmodule

// File: tb/tb_bm_expr_alu_pipe.sv
// Directed and randomised checks for bm_expr_alu_pipe (BITS=32, STAGES=2), plus a
// CNT_BITS=4 twin sharing the same stimulus for counter wrap.
module tb_bm_expr_alu_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [4:0]  opcode;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic        in_ready,  out_valid,  flag_zero,  flag_carry,  flag_illegal;
    logic [31:0] result;
    logic [15:0] op_count;
    logic        in_ready4, out_valid4, flag_zero4, flag_carry4, flag_illegal4;
    logic [31:0] result4;
    logic [3:0]  op_count4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    bm_expr_alu_pipe #(.BITS(32), .STAGES(2), .CNT_BITS(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flag_zero(flag_zero),
        .flag_carry(flag_carry), .flag_illegal(flag_illegal), .op_count(op_count)
    );

    bm_expr_alu_pipe #(.BITS(32), .STAGES(2), .CNT_BITS(4)) dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .opcode(opcode), .a_in(a_in), .b_in(b_in), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4), .flag_zero(flag_zero4),
        .flag_carry(flag_carry4), .flag_illegal(flag_illegal4), .op_count(op_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {illegal, carry, result}.
    function automatic logic [33:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint unsigned s;
        logic [31:0] r;
        logic c, il;
        r = 32'd0; c = 1'b0; il = 1'b0;
        case (op)
            5'd0:  r = {31'd0, (a != 0) && (b != 0)};
            5'd1:  r = {31'd0, (a != 0) || (b != 0)};
            5'd2:  r = {31'd0, a == b};
            5'd3:  r = {31'd0, a != b};
            5'd4:  r = {31'd0, a > b};
            5'd5:  r = {31'd0, a >= b};
            5'd6:  r = {31'd0, a < b};
            5'd7:  r = {31'd0, a <= b};
            5'd8: begin
                s = longint'(a) + longint'(b);
                c = (s > 64'h0000_0000_FFFF_FFFF);
                r = s[31:0];
`ifdef BM_EXPR_SAT_EN
                if (c) r = 32'hFFFF_FFFF;
`endif
            end
            5'd9: begin
                c = (a < b);
                r = a - b;
`ifdef BM_EXPR_SAT_EN
                if (c) r = 32'd0;
`endif
            end
            5'd10: r = (b < 32) ? (a << b[4:0]) : 32'd0;
            5'd11: r = (b < 32) ? (a >> b[4:0]) : 32'd0;
            5'd12: r = a & b;
            5'd13: r = a | b;
            5'd14: r = a ^ b;
            5'd15: r = ~(a ^ b);
            5'd16: r = ~a;
            5'd17: r = {31'd0, a == 0};
            5'd18: r = 32'd0 - a;
            default: il = 1'b1;
        endcase
        return {il, c, r};
    endfunction

    // Scoreboard: accepted beats are queued, delivered beats must match in order.
    logic [33:0] sb_q[$];
    logic [33:0] sb_e;
    int          cnt_exp;

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            sb_q.delete();
            cnt_exp = 0;
        end else begin
            if (in_valid && in_ready) sb_q.push_back(ref_op(opcode, a_in, b_in));
            if (out_valid && out_ready) begin
                cnt_exp++;
                if (sb_q.size() == 0) begin
                    check("mon_extra_beat", 32'(sb_q.size()), 32'd1);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("mon_result",  result,             sb_e[31:0]);
                    check("mon_zero",    32'(flag_zero),     32'(sb_e[31:0] == 32'd0));
                    check("mon_carry",   32'(flag_carry),    32'(sb_e[32]));
                    check("mon_illegal", 32'(flag_illegal),  32'(sb_e[33]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = v; opcode = op; a_in = a; b_in = b;
    endtask

    logic [4:0]  s_op  [8];
    logic [31:0] s_a   [8];
    logic [31:0] s_b   [8];
    logic [31:0] s_res [8];
    logic        s_cy  [8];
    logic        s_il  [8];
    int          sent;
    int          cyc;

    initial begin
        s_op[0] = 5'd9;  s_a[0] = 32'd5;          s_b[0] = 32'd7;
        s_op[1] = 5'd4;  s_a[1] = 32'd9;          s_b[1] = 32'd3;
        s_op[2] = 5'd10; s_a[2] = 32'd1;          s_b[2] = 32'd31;
        s_op[3] = 5'd11; s_a[3] = 32'd1;          s_b[3] = 32'd32;
        s_op[4] = 5'd15; s_a[4] = 32'hF0F0_F0F0;  s_b[4] = 32'h0F0F_0F0F;
        s_op[5] = 5'd18; s_a[5] = 32'd1;          s_b[5] = 32'd0;
        s_op[6] = 5'd17; s_a[6] = 32'd0;          s_b[6] = 32'd0;
        s_op[7] = 5'd25; s_a[7] = 32'd3;          s_b[7] = 32'd4;
`ifdef BM_EXPR_SAT_EN
        s_res[0] = 32'd0;
`else
        s_res[0] = 32'hFFFF_FFFE;
`endif
        s_res[1] = 32'd1;   s_res[2] = 32'h8000_0000; s_res[3] = 32'd0;
        s_res[4] = 32'd0;   s_res[5] = 32'hFFFF_FFFF; s_res[6] = 32'd1; s_res[7] = 32'd0;
        s_cy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        s_il = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; out_ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_result",    result,          32'd0);
        check("rst_flags",     32'({flag_zero, flag_carry, flag_illegal}), 32'd0);
        check("rst_op_count",  32'(op_count),   32'd0);

        // ADD overflow and two-cycle latency.
        out_ready = 1'b1;
        drive(1'b1, 5'd8, 32'hFFFF_FFFF, 32'd1);
        #1 check("add_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("add_lat1_valid", 32'(out_valid), 32'd0);
        step();
        check("add_lat2_valid", 32'(out_valid), 32'd1);
`ifdef BM_EXPR_SAT_EN
        check("add_result", result,            32'hFFFF_FFFF);
        check("add_zero",   32'(flag_zero),    32'd0);
`else
        check("add_result", result,            32'd0);
        check("add_zero",   32'(flag_zero),    32'd1);
`endif
        check("add_carry",  32'(flag_carry),   32'd1);
        step();
        check("add_drained", 32'(out_valid), 32'd0);

        // Back-to-back stream of 8 beats, one result per cycle.
        for (int c = 0; c < 9; c++) begin
            if (c < 8) drive(1'b1, s_op[c], s_a[c], s_b[c]);
            else in_valid = 1'b0;
            step();
            if (c >= 1) begin
                check("str_valid",   32'(out_valid),    32'd1);
                check("str_result",  result,            s_res[c-1]);
                check("str_carry",   32'(flag_carry),   32'(s_cy[c-1]));
                check("str_illegal", 32'(flag_illegal), 32'(s_il[c-1]));
            end
        end
        step();
        check("str_op_count", 32'(op_count), 32'd9);

        // Backpressure: two beats buffer, then in_ready drops and output holds.
        out_ready = 1'b0;
        drive(1'b1, 5'd12, 32'hFF00_FF00, 32'h0FF0_0FF0);
        #1 check("bp_rdy0", 32'(in_ready), 32'd1);
        step();
        drive(1'b1, 5'd13, 32'd1, 32'd2);
        #1 check("bp_rdy1", 32'(in_ready), 32'd1);
        step();
        drive(1'b1, 5'd14, 32'hA, 32'h3);
        #1 check("bp_full", 32'(in_ready), 32'd0);
        check("bp_hold_res0", result, 32'h0F00_0F00);
        step();
        check("bp_still_full", 32'(in_ready),  32'd0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_res1",  result,         32'h0F00_0F00);
        out_ready = 1'b1;
        #1 check("bp_release_rdy", 32'(in_ready), 32'd1);
        step();
        check("bp_out1", result, 32'd3);
        drive(1'b1, 5'd8, 32'd2, 32'd3);
        step();
        in_valid = 1'b0;
        check("bp_out2", result, 32'd9);
        step();
        check("bp_out3", result, 32'd5);
        step();
        check("bp_empty",    32'(out_valid), 32'd0);
        check("bp_op_count", 32'(op_count),  32'd13);

        // Randomised valid/ready traffic against the scoreboard.
        sent = 0; cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom,
                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        check("rnd_sent", 32'(sent), 32'd1000);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("rnd_drain",      32'(sb_q.size()), 32'd0);
        check("rnd_op_count",   32'(op_count),    32'(cnt_exp[15:0]));
        check("rnd_op_count4",  32'(op_count4),   32'(cnt_exp[3:0]));
        check("rnd_total",      32'(cnt_exp),     32'd1013);

        // Asynchronous reset with two beats in flight.
        drive(1'b1, 5'd8, 32'd1, 32'd1);
        step();
        drive(1'b1, 5'd12, 32'd7, 32'd3);
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_op_count",  32'(op_count),  32'd0);
        check("ar_op_count4", 32'(op_count4), 32'd0);
        check("ar_in_ready",  32'(in_ready),  32'd1);
        step();
        reset = 1'b0;
        drive(1'b1, 5'd13, 32'd4, 32'd1);
        step();
        in_valid = 1'b0;
        check("ar_lat1_valid", 32'(out_valid), 32'd0);
        step();
        check("ar_lat2_valid", 32'(out_valid), 32'd1);
        check("ar_result",     result,         32'd5);
        step();
        check("ar_op_count_after", 32'(op_count), 32'd1);

        // Counter wrap on the CNT_BITS=4 twin.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd8, 32'(i), 32'd0);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("wrap_op_count4", 32'(op_count4), 32'd1);
        check("wrap_op_count",  32'(op_count),  32'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
